// File: rtl/stim_seq_pkg.sv
// Shared types and LFSR helpers for the stimulus sequencer.
// Optional feature macro: STIM_SEQ_LFSR_EN (compiles the LFSR tap table and next-value function).
package stim_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

`ifdef STIM_SEQ_LFSR_EN
  // Maximal-length Fibonacci tap masks, bit i set means register bit i feeds the XOR
  function automatic logic [15:0] lfsr_taps(input int unsigned w);
    logic [15:0] taps;
    case (w)
      2:       taps = 16'h0003;
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0003;
    endcase
    return taps;
  endfunction

  // Shift left, feed XOR of taps into the LSB, trim to w bits
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur, input int unsigned w);
    logic [15:0] mask;
    logic        fb;
    mask = 16'((32'd1 << w) - 32'd1);
    fb   = ^(cur & lfsr_taps(w));
    return ((cur << 1) | {15'd0, fb}) & mask;
  endfunction
`endif

endpackage

// File: rtl/stim_lfsr.sv
// Next-value logic for the LFSR mode; load selects the (non-zero) seed.
// Optional feature macro: STIM_SEQ_LFSR_EN (module exists only when defined).
`ifdef STIM_SEQ_LFSR_EN
module stim_lfsr
  import stim_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEED  = 5
) (
  input  logic             load,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt_c
);

  // An all-zero seed would lock the register, so substitute 1
  localparam logic [WIDTH-1:0] SEED_LOAD =
    (WIDTH'(SEED) == '0) ? WIDTH'(1) : WIDTH'(SEED);

  // Seed on load, otherwise one LFSR step
  always_comb begin
    nxt_c = SEED_LOAD;
    if (!load) begin
      nxt_c = WIDTH'(lfsr_next(16'(cur), WIDTH));
    end
  end

endmodule
`endif

// File: rtl/stim_seq_gen.sv
// Stimulus sequencer: emits STEPS updates of a counter/LFSR value, one every PERIOD cycles.
// Optional feature macro: STIM_SEQ_LFSR_EN (enables LFSR mode; otherwise mode and SEED are ignored).
module stim_seq_gen
  import stim_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEPS  = 2,
  parameter int unsigned PERIOD = 10,
  parameter int unsigned SEED   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  output logic [WIDTH-1:0] seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CYC_W  = $clog2(PERIOD + 1);
  localparam int unsigned STEP_W = $clog2(STEPS + 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(PERIOD - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  seq_q, seq_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  load_val_c;
  logic [WIDTH-1:0]  step_val_c;

`ifdef STIM_SEQ_LFSR_EN
  logic             mode_q, mode_d;
  logic             load_c;
  logic [WIDTH-1:0] lfsr_nxt_c;

  assign load_c = (state_q == ST_IDLE) && start;

  stim_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .load  (load_c),
    .cur   (seq_q),
    .nxt_c (lfsr_nxt_c)
  );

  // Start value uses the live mode pin, updates use the latched mode
  always_comb begin
    load_val_c = mode ? lfsr_nxt_c : '0;
    step_val_c = mode_q ? lfsr_nxt_c : seq_q + WIDTH'(1);
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^{mode, WIDTH'(SEED)};

  // Pure counter: start at zero, increment with silent wrap
  always_comb begin
    load_val_c = '0;
    step_val_c = seq_q + WIDTH'(1);
  end
`endif

  // Next-state, counters and output intents
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    step_d  = step_q;
    seq_d   = seq_q;
    valid_d = 1'b0;
`ifdef STIM_SEQ_LFSR_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cyc_d   = '0;
          step_d  = '0;
          seq_d   = load_val_c;
`ifdef STIM_SEQ_LFSR_EN
          mode_d  = mode;
`endif
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cyc_q == CYC_LAST) begin
          if (step_q < STEP_LAST) begin
            seq_d   = step_val_c;
            valid_d = 1'b1;
            step_d  = step_q + STEP_W'(1);
            cyc_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      step_q  <= '0;
      seq_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STIM_SEQ_LFSR_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      step_q  <= step_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef STIM_SEQ_LFSR_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign seq_out   = seq_q;
  assign seq_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_stim_seq_gen.sv
// Self-checking bench for stim_seq_gen: checkpoint table, update scoreboards, corner sequences.
module tb_stim_seq_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Config A: WIDTH=4, STEPS=2, PERIOD=10
  logic start_a = 0, abort_a = 0, mode_a = 0;
  logic [3:0] seq_a;
  logic valid_a, busy_a, done_a;
  stim_seq_gen #(.WIDTH(4), .STEPS(2), .PERIOD(10), .SEED(5)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode(mode_a),
    .seq_out(seq_a), .seq_valid(valid_a), .busy(busy_a), .done(done_a));

  // Config B: WIDTH=4, STEPS=20, PERIOD=1
  logic start_b = 0, abort_b = 0, mode_b = 0;
  logic [3:0] seq_b;
  logic valid_b, busy_b, done_b;
  stim_seq_gen #(.WIDTH(4), .STEPS(20), .PERIOD(1), .SEED(5)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode(mode_b),
    .seq_out(seq_b), .seq_valid(valid_b), .busy(busy_b), .done(done_b));

  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  int done_cnt_a = 0;

  // Scoreboards: each seq_valid pops the value expected at stimulus time
  always @(negedge clk) begin
    if (!rst && valid_a) begin
      if (q_a.size() == 0) check("sb_a_unexpected_valid", int'(q_a.size()), 1);
      else check("sb_a_value", int'(seq_a), int'(q_a.pop_front()));
    end
    if (!rst && done_a) done_cnt_a++;
    if (!rst && valid_b) begin
      if (q_b.size() == 0) check("sb_b_unexpected_valid", int'(q_b.size()), 1);
      else check("sb_b_value", int'(seq_b), int'(q_b.pop_front()));
    end
  end

`ifdef STIM_SEQ_LFSR_EN
  // Config C: LFSR, SEED=5, STEPS=3, PERIOD=2
  logic start_c = 0, abort_c = 0, mode_c = 0;
  logic [3:0] seq_c;
  logic valid_c, busy_c, done_c;
  stim_seq_gen #(.WIDTH(4), .STEPS(3), .PERIOD(2), .SEED(5)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .mode(mode_c),
    .seq_out(seq_c), .seq_valid(valid_c), .busy(busy_c), .done(done_c));

  // Config D: LFSR, SEED=0, STEPS=15, PERIOD=1
  logic start_d = 0, abort_d = 0, mode_d = 0;
  logic [3:0] seq_d;
  logic valid_d, busy_d, done_d;
  stim_seq_gen #(.WIDTH(4), .STEPS(15), .PERIOD(1), .SEED(0)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .abort(abort_d), .mode(mode_d),
    .seq_out(seq_d), .seq_valid(valid_d), .busy(busy_d), .done(done_d));

  logic [3:0] q_c[$];
  logic [3:0] q_d[$];

  always @(negedge clk) begin
    if (!rst && valid_c) begin
      if (q_c.size() == 0) check("sb_c_unexpected_valid", int'(q_c.size()), 1);
      else check("sb_c_value", int'(seq_c), int'(q_c.pop_front()));
    end
    if (!rst && valid_d) begin
      if (q_d.size() == 0) check("sb_d_unexpected_valid", int'(q_d.size()), 1);
      else check("sb_d_value", int'(seq_d), int'(q_d.pop_front()));
    end
  end

  // Reference x^4+x^3+1 step
  function automatic logic [3:0] lfsr4(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction
`endif

  typedef struct {
    int         cyc;
    logic [3:0] seq;
    logic       valid;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[8];

  // Basic config-A run: checkpoints are cycles after the start-sampling edge
  task automatic run_basic(input string tag);
    int idx = 0;
    int busy_cnt = 0;
    @(negedge clk);
    start_a = 1;
    q_a.push_back(4'd1);
    q_a.push_back(4'd2);
    @(negedge clk);
    start_a = 0;
    for (int c = 0; c <= 31; c++) begin
      if (busy_a) busy_cnt++;
      if (idx < 8 && tbl[idx].cyc == c) begin
        check($sformatf("%s_seq_c%0d", tag, c),   int'(seq_a),   int'(tbl[idx].seq));
        check($sformatf("%s_valid_c%0d", tag, c), int'(valid_a), int'(tbl[idx].valid));
        check($sformatf("%s_busy_c%0d", tag, c),  int'(busy_a),  int'(tbl[idx].busy));
        check($sformatf("%s_done_c%0d", tag, c),  int'(done_a),  int'(tbl[idx].done));
        idx++;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, busy_cnt, 30);
    check({tag, "_queue_drained"}, int'(q_a.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int vcnt, first, last, dcyc, zeros;
    logic [3:0] s;

    tbl[0] = '{0,  4'd0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{9,  4'd0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{10, 4'd1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{11, 4'd1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{20, 4'd2, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{29, 4'd2, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{30, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{31, 4'd2, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1;
    #1;
    check("rst_seq",   int'(seq_a),   0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_busy",  int'(busy_a),  0);
    check("rst_done",  int'(done_a),  0);
    repeat (2) @(negedge clk);
    rst = 0;

    run_basic("basic");

    // Abort sampled at E16, restart sampled at E17
    d0 = done_cnt_a;
    @(negedge clk);
    start_a = 1;
    q_a.push_back(4'd1);
    @(negedge clk);
    start_a = 0;
    repeat (15) @(negedge clk);
    abort_a = 1;
    @(negedge clk);
    abort_a = 0;
    check("abort_busy",  int'(busy_a),  0);
    check("abort_seq",   int'(seq_a),   1);
    check("abort_valid", int'(valid_a), 0);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    check("restart_seq",  int'(seq_a),  0);
    check("restart_busy", int'(busy_a), 1);
    q_a.push_back(4'd1);
    q_a.push_back(4'd2);
    repeat (32) @(negedge clk);
    check("abort_restart_done_pulses", done_cnt_a - d0, 1);
    check("abort_restart_queue", int'(q_a.size()), 0);

    // Asynchronous reset between edges at E25
    @(negedge clk);
    start_a = 1;
    q_a.push_back(4'd1);
    q_a.push_back(4'd2);
    @(negedge clk);
    start_a = 0;
    repeat (25) @(negedge clk);
    rst = 1;
    #1;
    check("midrst_seq",  int'(seq_a),  0);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_done", int'(done_a), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    check("midrst_queue", int'(q_a.size()), 0);
    run_basic("after_rst");

    // Counter wrap, update every cycle; mode is don't-care without LFSR support
`ifdef STIM_SEQ_LFSR_EN
    mode_b = 0;
`else
    mode_b = 1;
`endif
    @(negedge clk);
    start_b = 1;
    for (int k = 1; k <= 20; k++) q_b.push_back(4'(k));
    @(negedge clk);
    start_b = 0;
    check("wrap_load", int'(seq_b), 0);
    vcnt = 0; first = -1; last = -1; dcyc = -1;
    for (int c = 0; c <= 24; c++) begin
      if (valid_b) begin
        vcnt++;
        if (first < 0) first = c;
        last = c;
      end
      if (done_b && dcyc < 0) dcyc = c;
      @(negedge clk);
    end
    check("wrap_valid_count", vcnt, 20);
    check("wrap_first_valid", first, 1);
    check("wrap_last_valid", last, 20);
    check("wrap_done_cycle", dcyc, 21);
    check("wrap_final_seq", int'(seq_b), 4);
    check("wrap_queue", int'(q_b.size()), 0);

`ifdef STIM_SEQ_LFSR_EN
    // LFSR seed 5; mode dropped after start must be ignored
    @(negedge clk);
    mode_c = 1;
    start_c = 1;
    q_c.push_back(4'hB);
    q_c.push_back(4'h7);
    q_c.push_back(4'hF);
    @(negedge clk);
    start_c = 0;
    mode_c = 0;
    check("lfsr_seed", int'(seq_c), 5);
    first = -1; dcyc = -1;
    for (int c = 0; c <= 10; c++) begin
      if (valid_c && first < 0) first = c;
      if (done_c && dcyc < 0) dcyc = c;
      @(negedge clk);
    end
    check("lfsr_first_valid", first, 2);
    check("lfsr_done_cycle", dcyc, 8);
    check("lfsr_final", int'(seq_c), 15);
    check("lfsr_queue", int'(q_c.size()), 0);

    // LFSR with zero seed never reaches zero
    @(negedge clk);
    mode_d = 1;
    start_d = 1;
    s = 4'd1;
    for (int k = 0; k < 15; k++) begin
      s = lfsr4(s);
      q_d.push_back(s);
    end
    @(negedge clk);
    start_d = 0;
    check("lfsr0_load", int'(seq_d), 1);
    zeros = 0;
    for (int c = 0; c <= 17; c++) begin
      if (seq_d == 4'd0) zeros++;
      @(negedge clk);
    end
    check("lfsr0_zero_seen", zeros, 0);
    check("lfsr0_queue", int'(q_d.size()), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
